// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, decode IR, execute T3-T6, then halt or refetch.
module control_sequencer #(
    parameter int unsigned IR_WIDTH = 32,
    parameter int unsigned OP_WIDTH = 5
) (
    input  logic                Clock_i,
    input  logic                Clear_i,
    input  logic [IR_WIDTH-1:0] IR_i,
    input  logic                Stop_i,
    output logic                PCout_o,
    output logic                Zlowout_o,
    output logic                ZHighout_o,
    output logic                HIout_o,
    output logic                LOout_o,
    output logic                MDRout_o,
    output logic                Cout_o,
    output logic                MARin_o,
    output logic                PCin_o,
    output logic                MDRin_o,
    output logic                IRin_o,
    output logic                Yin_o,
    output logic                ZLowIn_o,
    output logic                ZHighIn_o,
    output logic                HIin_o,
    output logic                LOin_o,
    output logic                IncPC_o,
    output logic                Read_o,
    output logic                Gra_o,
    output logic                Grb_o,
    output logic                Grc_o,
    output logic                Rin_o,
    output logic                Rout_o,
    output logic [OP_WIDTH-1:0] ALU_op_o,
    output logic                Run_o,
    output logic                Illegal_o
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_IMM,
        C_MULDIV,
        C_UNARY,
        C_NOP,
        C_HALT,
        C_ILLEGAL
    } op_class_e;

    state_e              state_q, state_d;
    op_class_e           op_class;
    logic [OP_WIDTH-1:0] opcode;
    logic [OP_WIDTH-1:0] imm_alu;
    logic                boundary;
    logic                unused_ir_bits;

    assign opcode         = IR_i[IR_WIDTH-1 -: OP_WIDTH];
    assign unused_ir_bits = ^IR_i[IR_WIDTH-OP_WIDTH-1:0];

    // Classify the opcode and map immediate forms onto their register ALU codes.
    always_comb begin
        op_class = C_ILLEGAL;
        imm_alu  = OP_WIDTH'(5'b00011);
        if (opcode >= OP_WIDTH'(5'b00011) && opcode <= OP_WIDTH'(5'b01011)) begin
            op_class = C_RTYPE;
        end else if (opcode >= OP_WIDTH'(5'b01100) && opcode <= OP_WIDTH'(5'b01110)) begin
            op_class = C_IMM;
        end else if (opcode == OP_WIDTH'(5'b01111) || opcode == OP_WIDTH'(5'b10000)) begin
            op_class = C_MULDIV;
        end else if (opcode == OP_WIDTH'(5'b10001) || opcode == OP_WIDTH'(5'b10010)) begin
            op_class = C_UNARY;
        end else if (opcode == OP_WIDTH'(5'b11010)) begin
            op_class = C_NOP;
        end else if (opcode == OP_WIDTH'(5'b11011)) begin
            op_class = C_HALT;
        end
        if (opcode == OP_WIDTH'(5'b01101)) begin
            imm_alu = OP_WIDTH'(5'b00101);
        end else if (opcode == OP_WIDTH'(5'b01110)) begin
            imm_alu = OP_WIDTH'(5'b00110);
        end
    end

    // State register; Clear wins over everything, including mid-instruction.
    always_ff @(posedge Clock_i) begin
        if (Clear_i) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore strobe decode from state and opcode.
    always_comb begin
        state_d    = state_q;
        boundary   = 1'b0;
        PCout_o    = 1'b0;
        Zlowout_o  = 1'b0;
        ZHighout_o = 1'b0;
        HIout_o    = 1'b0;
        LOout_o    = 1'b0;
        MDRout_o   = 1'b0;
        Cout_o     = 1'b0;
        MARin_o    = 1'b0;
        PCin_o     = 1'b0;
        MDRin_o    = 1'b0;
        IRin_o     = 1'b0;
        Yin_o      = 1'b0;
        ZLowIn_o   = 1'b0;
        ZHighIn_o  = 1'b0;
        HIin_o     = 1'b0;
        LOin_o     = 1'b0;
        IncPC_o    = 1'b0;
        Read_o     = 1'b0;
        Gra_o      = 1'b0;
        Grb_o      = 1'b0;
        Grc_o      = 1'b0;
        Rin_o      = 1'b0;
        Rout_o     = 1'b0;
        ALU_op_o   = '0;
        Run_o      = 1'b0;
        Illegal_o  = 1'b0;

        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                Run_o = 1'b1; PCout_o = 1'b1; MARin_o = 1'b1; IncPC_o = 1'b1; ZLowIn_o = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Run_o = 1'b1; Zlowout_o = 1'b1; PCin_o = 1'b1; Read_o = 1'b1; MDRin_o = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                Run_o = 1'b1; MDRout_o = 1'b1; IRin_o = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                Run_o = 1'b1;
                state_d = S_T4;
                case (op_class)
                    C_RTYPE, C_IMM: begin Grb_o = 1'b1; Rout_o = 1'b1; Yin_o = 1'b1; end
                    C_MULDIV:       begin Gra_o = 1'b1; Rout_o = 1'b1; Yin_o = 1'b1; end
                    C_UNARY: begin
                        Grb_o = 1'b1; Rout_o = 1'b1; ZLowIn_o = 1'b1; ALU_op_o = opcode;
                    end
                    C_HALT:    state_d = S_HALT;
                    C_ILLEGAL: begin Illegal_o = 1'b1; boundary = 1'b1; end
                    default:   boundary = 1'b1;
                endcase
            end
            S_T4: begin
                Run_o = 1'b1;
                state_d = S_T5;
                case (op_class)
                    C_RTYPE: begin
                        Grc_o = 1'b1; Rout_o = 1'b1; ZLowIn_o = 1'b1; ALU_op_o = opcode;
                    end
                    C_IMM: begin Cout_o = 1'b1; ZLowIn_o = 1'b1; ALU_op_o = imm_alu; end
                    C_MULDIV: begin
                        Grb_o = 1'b1; Rout_o = 1'b1; ZLowIn_o = 1'b1; ZHighIn_o = 1'b1;
                        ALU_op_o = opcode;
                    end
                    C_UNARY: begin Zlowout_o = 1'b1; Gra_o = 1'b1; Rin_o = 1'b1; boundary = 1'b1; end
                    default: boundary = 1'b1;
                endcase
            end
            S_T5: begin
                Run_o = 1'b1;
                case (op_class)
                    C_RTYPE, C_IMM: begin
                        Zlowout_o = 1'b1; Gra_o = 1'b1; Rin_o = 1'b1; boundary = 1'b1;
                    end
                    C_MULDIV: begin Zlowout_o = 1'b1; LOin_o = 1'b1; state_d = S_T6; end
                    default:  boundary = 1'b1;
                endcase
            end
            S_T6: begin
                Run_o = 1'b1; ZHighout_o = 1'b1; HIin_o = 1'b1; boundary = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase

        // Instruction boundary: Stop is only honoured here.
        if (boundary) begin
            state_d = Stop_i ? S_HALT : S_T0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer against a phase-list reference model.
module tb_control_sequencer;

    localparam int unsigned IR_WIDTH = 32;
    localparam int unsigned OP_WIDTH = 5;
    localparam int NCYCLES = 4000;

    // Bit positions of the packed strobe vector.
    localparam int B_PCOUT = 0,  B_ZLOWOUT = 1, B_ZHIGHOUT = 2, B_HIOUT = 3, B_LOOUT = 4;
    localparam int B_MDROUT = 5, B_COUT = 6,    B_MARIN = 7,    B_PCIN = 8,  B_MDRIN = 9;
    localparam int B_IRIN = 10,  B_YIN = 11,    B_ZLOWIN = 12,  B_ZHIGHIN = 13, B_HIIN = 14;
    localparam int B_LOIN = 15,  B_INCPC = 16,  B_READ = 17,    B_GRA = 18,  B_GRB = 19;
    localparam int B_GRC = 20,   B_RIN = 21,    B_ROUT = 22,    B_RUN = 23,  B_ILLEGAL = 24;

    localparam int M_RESET = 0, M_RUN = 1, M_HALT = 2;

    typedef struct {
        logic [31:0] ir;
        int          stop_pos;
        int          clear_pos;
    } instr_t;

    logic                Clock = 1'b0;
    logic                Clear, Stop;
    logic [IR_WIDTH-1:0] IR;
    logic PCout, Zlowout, ZHighout, HIout, LOout, MDRout, Cout;
    logic MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
    logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, Illegal;
    logic [OP_WIDTH-1:0] ALU_op;
    logic [29:0]         act;

    always #5 Clock = ~Clock;

    control_sequencer #(.IR_WIDTH(IR_WIDTH), .OP_WIDTH(OP_WIDTH)) dut (
        .Clock_i(Clock), .Clear_i(Clear), .IR_i(IR), .Stop_i(Stop),
        .PCout_o(PCout), .Zlowout_o(Zlowout), .ZHighout_o(ZHighout), .HIout_o(HIout),
        .LOout_o(LOout), .MDRout_o(MDRout), .Cout_o(Cout), .MARin_o(MARin), .PCin_o(PCin),
        .MDRin_o(MDRin), .IRin_o(IRin), .Yin_o(Yin), .ZLowIn_o(ZLowIn), .ZHighIn_o(ZHighIn),
        .HIin_o(HIin), .LOin_o(LOin), .IncPC_o(IncPC), .Read_o(Read), .Gra_o(Gra),
        .Grb_o(Grb), .Grc_o(Grc), .Rin_o(Rin), .Rout_o(Rout), .ALU_op_o(ALU_op),
        .Run_o(Run), .Illegal_o(Illegal)
    );

    assign act = {ALU_op, Illegal, Run, Rout, Rin, Grc, Grb, Gra, Read, IncPC,
                  LOin, HIin, ZHighIn, ZLowIn, Yin, IRin, MDRin, PCin, MARin,
                  Cout, MDRout, LOout, HIout, ZHighout, Zlowout, PCout};

    function automatic logic [29:0] b(input int idx);
        return 30'(1) << idx;
    endfunction

    function automatic logic [29:0] alu(input logic [4:0] op);
        return {op, 25'd0};
    endfunction

    // 0 R-type, 1 immediate, 2 mul/div, 3 unary, 4 nop, 5 halt, 6 illegal
    function automatic int op_class(input logic [4:0] op);
        int v = int'(op);
        if (v >= 3 && v <= 11) return 0;
        if (v >= 12 && v <= 14) return 1;
        if (v == 15 || v == 16) return 2;
        if (v == 17 || v == 18) return 3;
        if (v == 26) return 4;
        if (v == 27) return 5;
        return 6;
    endfunction

    function automatic int exec_len(input logic [4:0] op);
        case (op_class(op))
            0, 1:    return 3;
            2:       return 4;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [29:0] fetch_vec(input int k);
        case (k)
            0:       return b(B_RUN) | b(B_PCOUT) | b(B_MARIN) | b(B_INCPC) | b(B_ZLOWIN);
            1:       return b(B_RUN) | b(B_ZLOWOUT) | b(B_PCIN) | b(B_READ) | b(B_MDRIN);
            default: return b(B_RUN) | b(B_MDROUT) | b(B_IRIN);
        endcase
    endfunction

    function automatic logic [29:0] exec_vec(input logic [4:0] op, input int k);
        logic [29:0] v = b(B_RUN);
        logic [4:0]  imm_op = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
        case (op_class(op))
            0: case (k)
                   0:       v |= b(B_GRB) | b(B_ROUT) | b(B_YIN);
                   1:       v |= b(B_GRC) | b(B_ROUT) | b(B_ZLOWIN) | alu(op);
                   default: v |= b(B_ZLOWOUT) | b(B_GRA) | b(B_RIN);
               endcase
            1: case (k)
                   0:       v |= b(B_GRB) | b(B_ROUT) | b(B_YIN);
                   1:       v |= b(B_COUT) | b(B_ZLOWIN) | alu(imm_op);
                   default: v |= b(B_ZLOWOUT) | b(B_GRA) | b(B_RIN);
               endcase
            2: case (k)
                   0:       v |= b(B_GRA) | b(B_ROUT) | b(B_YIN);
                   1:       v |= b(B_GRB) | b(B_ROUT) | b(B_ZLOWIN) | b(B_ZHIGHIN) | alu(op);
                   2:       v |= b(B_ZLOWOUT) | b(B_LOIN);
                   default: v |= b(B_ZHIGHOUT) | b(B_HIIN);
               endcase
            3: case (k)
                   0:       v |= b(B_GRB) | b(B_ROUT) | b(B_ZLOWIN) | alu(op);
                   default: v |= b(B_ZLOWOUT) | b(B_GRA) | b(B_RIN);
               endcase
            6:       v |= b(B_ILLEGAL);
            default: v = v;
        endcase
        return v;
    endfunction

    // Scoreboard and model state
    logic [29:0] exp_q[$];
    instr_t      dir_q[$];
    instr_t      cur;
    int          mode, pos, halt_cnt, halt_wait, init_clear;
    int          checks = 0, errors = 0, pushes = 0;
    bit          prev_clear, prev_stop;

    task automatic new_instr();
        logic [4:0] op;
        pos = 0;
        if (dir_q.size() > 0) begin
            cur = dir_q.pop_front();
            halt_wait = 20;
        end else begin
            op = 5'($urandom_range(0, 31));
            cur.ir = {op, 27'($urandom)};
            cur.stop_pos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 + exec_len(op))) : -1;
            cur.clear_pos = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 6)) : -1;
            halt_wait = int'($urandom_range(1, 5));
        end
    endtask

    // Step the model across one rising edge using last cycle's inputs.
    task automatic advance();
        logic [4:0] op = cur.ir[31:27];
        if (prev_clear) begin
            mode = M_RESET;
        end else if (mode == M_RESET) begin
            mode = M_RUN;
            new_instr();
        end else if (mode == M_RUN) begin
            if (pos >= 3 && op_class(op) == 5) begin
                mode = M_HALT; halt_cnt = 0;
            end else if (pos == 2 + exec_len(op)) begin
                if (prev_stop) begin
                    mode = M_HALT; halt_cnt = 0;
                end else begin
                    new_instr();
                end
            end else begin
                pos++;
            end
        end else begin
            halt_cnt++;
        end
    endtask

    function automatic logic [29:0] expected();
        if (mode != M_RUN) return '0;
        if (pos < 3) return fetch_vec(pos);
        return exec_vec(cur.ir[31:27], pos - 3);
    endfunction

    // Stimulus: drive each cycle and queue the model's expected strobes.
    initial begin
        Clear = 1'b1; Stop = 1'b0; IR = '0;
        init_clear = 1;
        prev_clear = 1'b1; prev_stop = 1'b0;
        mode = M_RESET; pos = 0; halt_cnt = 0; halt_wait = 20;
        cur = '{32'h0, -1, -1};
        dir_q.push_back('{32'h22920000, -1, -1});            // sub R5,R2,R4
        dir_q.push_back('{{5'b01100, 27'h0123456}, -1, -1}); // addi
        dir_q.push_back('{{5'b01111, 27'h0340000}, -1, -1}); // mul
        dir_q.push_back('{{5'b11111, 27'h0}, -1, -1});       // undefined
        dir_q.push_back('{{5'b00011, 27'h0}, 4, -1});        // Stop in T4 ignored
        dir_q.push_back('{{5'b00101, 27'h0}, 5, -1});        // Stop in T5 halts
        dir_q.push_back('{{5'b00110, 27'h0}, -1, 4});        // Clear in T4
        dir_q.push_back('{{5'b10001, 27'h0}, -1, -1});       // neg
        dir_q.push_back('{{5'b10000, 27'h0}, 6, -1});        // div, Stop in T6 halts
        dir_q.push_back('{{5'b11010, 27'h0}, 3, -1});        // nop, Stop in T3 halts
        dir_q.push_back('{{5'b10010, 27'h0}, -1, -1});       // not
        dir_q.push_back('{{5'b11011, 27'h0}, -1, -1});       // halt opcode
        for (int c = 0; c < NCYCLES; c++) begin
            @(posedge Clock);
            #1;
            advance();
            Clear = 1'b0;
            Stop  = 1'b0;
            if (init_clear > 0) begin
                Clear = 1'b1;
                init_clear--;
            end
            if (mode == M_RUN) begin
                IR = (pos < 2) ? $urandom : cur.ir;
                if (pos == cur.stop_pos) Stop = 1'b1;
                if (pos == cur.clear_pos) Clear = 1'b1;
            end else begin
                IR   = $urandom;
                Stop = 1'($urandom_range(0, 1));
                if (mode == M_HALT && halt_cnt >= halt_wait) Clear = 1'b1;
            end
            exp_q.push_back(expected());
            pushes++;
            prev_clear = Clear;
            prev_stop  = Stop;
        end
        @(posedge Clock);
        @(negedge Clock);
        #1;
        checks++;
        if (exp_q.size() != 0 || checks - 1 != pushes) begin
            errors++;
            $display("FAIL drain: popped %0d of %0d expected entries", checks - 1, pushes);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: pops one expected strobe vector per cycle, mid-cycle.
    initial begin
        logic [29:0] e;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL strobes at %0t: got %h expected %h (alu got %0d exp %0d)",
                             $time, act, e, act[29:25], e[29:25]);
                end
            end
        end
    end

endmodule
